// File: rtl/eth_pkg.sv
// Shared constants and the receive state type for the Ethernet/IPv4/UDP receive path.
package eth_pkg;

    localparam int unsigned ETH_HDR_LEN  = 14;
    localparam int unsigned VLAN_TAG_LEN = 4;
    localparam logic [15:0] TPID         = 16'h8100;
    localparam logic [15:0] ETYPE_IPV4   = 16'h0800;
    localparam int unsigned IP_HDR_LEN   = 20;
    localparam logic [7:0]  IP_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
    localparam int unsigned UDP_HDR_LEN  = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_HDR,
        RX_PAYLOAD,
        RX_DROP
    } rx_state_t;

endpackage

// File: rtl/eth_udp_rx_filter.sv
// Per-byte header check: flags a byte whose value is wrong for its header offset.
module eth_udp_rx_filter
    import eth_pkg::*;
#(
    parameter int          VLAN_TAG          = 1,
    parameter int          MATCH_IP_SRC_ADDR = 1,
    parameter int          MATCH_IP_DST_ADDR = 1,
    parameter logic [31:0] IP_SRC_ADDR       = 32'h1,
    parameter logic [31:0] IP_DST_ADDR       = 32'h0,
    parameter int          OFF_W             = 7
) (
    input  logic [OFF_W-1:0] i_off,
    input  logic [7:0]       i_byte,
    output logic             o_fail
);

    localparam int unsigned VLAN_LEN  = (VLAN_TAG != 0) ? VLAN_TAG_LEN : 0;
    localparam int unsigned TPID_OFF  = ETH_HDR_LEN - 2;
    localparam int unsigned ETYPE_OFF = ETH_HDR_LEN - 2 + VLAN_LEN;
    localparam int unsigned IP_OFF    = ETH_HDR_LEN + VLAN_LEN;

    logic [31:0] w_off;

    assign w_off = 32'(i_off);

    // Compare the byte against the value required at its offset; unchecked offsets pass.
    always_comb begin
        o_fail = 1'b0;
        if ((VLAN_TAG != 0) && (w_off == TPID_OFF))
            o_fail = (i_byte != TPID[15:8]);
        if ((VLAN_TAG != 0) && (w_off == TPID_OFF + 1))
            o_fail = (i_byte != TPID[7:0]);
        if (w_off == ETYPE_OFF)
            o_fail = (i_byte != ETYPE_IPV4[15:8]);
        if (w_off == ETYPE_OFF + 1)
            o_fail = (i_byte != ETYPE_IPV4[7:0]);
        if (w_off == IP_OFF)
            o_fail = (i_byte != IP_VER_IHL);
        if (w_off == IP_OFF + 9)
            o_fail = (i_byte != IP_PROTO_UDP);
        for (int unsigned k = 0; k < 4; k++) begin
            if ((MATCH_IP_SRC_ADDR != 0) && (w_off == IP_OFF + 12 + k))
                o_fail = (i_byte != IP_SRC_ADDR[8*(3-k) +: 8]);
            if ((MATCH_IP_DST_ADDR != 0) && (w_off == IP_OFF + 16 + k))
                o_fail = (i_byte != IP_DST_ADDR[8*(3-k) +: 8]);
        end
    end

endmodule

// File: rtl/eth_udp_rx.sv
// Ethernet/IPv4/UDP receive header stripper: delivers only the UDP payload.
module eth_udp_rx
    import eth_pkg::*;
#(
    parameter int          IS_10G            = 1,
    parameter int          VLAN_TAG          = 1,
    parameter int          DATA_W            = 16,
    parameter int          MATCH_IP_SRC_ADDR = 1,
    parameter int          MATCH_IP_DST_ADDR = 1,
    parameter logic [31:0] IP_SRC_ADDR       = 32'h1,
    parameter logic [31:0] IP_DST_ADDR       = 32'h0,
    localparam int         KEEP_W            = DATA_W / 8,
    localparam int         LEN_W             = $clog2(KEEP_W + 1),
    localparam int         LANE0_CNT_N       = ((IS_10G != 0) && (DATA_W == 64)) ? 2 : 1
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   phy_cancel_i,
    input  logic                   mac_valid_i,
    input  logic [DATA_W-1:0]      mac_data_i,
    input  logic [LANE0_CNT_N-1:0] mac_start_i,
    input  logic                   mac_term_i,
    input  logic [LEN_W-1:0]       mac_len_i,
    output logic                   app_valid_o,
    output logic                   app_start_o,
    output logic                   app_cancel_o,
    output logic [DATA_W-1:0]      app_data_o,
    output logic [LEN_W-1:0]       app_len_o
);

    localparam int unsigned HDR_LEN  = ETH_HDR_LEN + ((VLAN_TAG != 0) ? VLAN_TAG_LEN : 0)
                                     + IP_HDR_LEN + UDP_HDR_LEN;
    localparam int unsigned ULEN_OFF = HDR_LEN - UDP_HDR_LEN + 4;
    localparam int          CNT_W    = 7;

    rx_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [15:0]           r_remain;
    logic [7:0]            r_len_hi;
    logic [7:0]            r_len_lo;
    logic                  r_emitted;
    logic                  r_valid;
    logic                  r_start;
    logic                  r_cancel;
    logic [DATA_W-1:0]     r_data;
    logic [LEN_W-1:0]      r_len;

    logic                  w_start;
    logic                  w_hdr_beat;
    logic [CNT_W-1:0]      w_base;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_hdr_done;
    logic [KEEP_W*CNT_W-1:0] w_lane_off;
    logic [KEEP_W-1:0]     w_lane_fail;
    logic                  w_hdr_fail;
    logic [7:0]            w_len_hi;
    logic [7:0]            w_len_lo;
    logic [15:0]           w_udp_len;
    logic [15:0]           w_mac_len;
    logic [15:0]           w_take;

    assign w_start    = |mac_start_i;
    assign w_hdr_beat = w_start || (r_state == RX_HDR);
    // A start beat always restarts header offsets at zero, even mid-frame.
    assign w_base     = (r_state == RX_HDR && !w_start) ? r_cnt : '0;
    assign w_cnt_next = w_base + CNT_W'(KEEP_W);
    assign w_hdr_done = (w_cnt_next == CNT_W'(HDR_LEN));
    assign w_hdr_fail = |w_lane_fail;
    assign w_udp_len  = {w_len_hi, w_len_lo};
    assign w_mac_len  = 16'(mac_len_i);
    assign w_take     = (w_mac_len < r_remain) ? w_mac_len : r_remain;

    genvar gi;
    for (gi = 0; gi < KEEP_W; gi++) begin : g_lane
        assign w_lane_off[gi*CNT_W +: CNT_W] = w_base + CNT_W'(gi);

        eth_udp_rx_filter #(
            .VLAN_TAG          (VLAN_TAG),
            .MATCH_IP_SRC_ADDR (MATCH_IP_SRC_ADDR),
            .MATCH_IP_DST_ADDR (MATCH_IP_DST_ADDR),
            .IP_SRC_ADDR       (IP_SRC_ADDR),
            .IP_DST_ADDR       (IP_DST_ADDR),
            .OFF_W             (CNT_W)
        ) u_filter (
            .i_off  (w_lane_off[gi*CNT_W +: CNT_W]),
            .i_byte (mac_data_i[8*gi +: 8]),
            .o_fail (w_lane_fail[gi])
        );
    end

    // UDP length as seen after this beat, so the last header beat can use it directly.
    always_comb begin
        w_len_hi = r_len_hi;
        w_len_lo = r_len_lo;
        for (int unsigned j = 0; j < KEEP_W; j++) begin
            if (32'(w_lane_off[j*CNT_W +: CNT_W]) == ULEN_OFF)
                w_len_hi = mac_data_i[8*j +: 8];
            if (32'(w_lane_off[j*CNT_W +: CNT_W]) == ULEN_OFF + 1)
                w_len_lo = mac_data_i[8*j +: 8];
        end
    end

    // Receive FSM with registered application outputs.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_remain  <= '0;
            r_len_hi  <= '0;
            r_len_lo  <= '0;
            r_emitted <= 1'b0;
            r_valid   <= 1'b0;
            r_start   <= 1'b0;
            r_cancel  <= 1'b0;
            r_data    <= '0;
            r_len     <= '0;
        end else begin
            r_valid  <= 1'b0;
            r_start  <= 1'b0;
            r_cancel <= 1'b0;
            if (mac_valid_i) begin
                if (phy_cancel_i) begin
                    r_cancel  <= r_emitted;
                    r_emitted <= 1'b0;
                    r_state   <= RX_IDLE;
                end else if (w_hdr_beat) begin
                    if (w_start) begin
                        r_cancel  <= r_emitted;
                        r_emitted <= 1'b0;
                    end
                    r_cnt    <= w_cnt_next;
                    r_len_hi <= w_len_hi;
                    r_len_lo <= w_len_lo;
                    if (mac_term_i) begin
                        r_state <= RX_IDLE;
                    end else if (w_hdr_fail) begin
                        r_state <= RX_DROP;
                    end else if (w_hdr_done) begin
                        if (w_udp_len > 16'(UDP_HDR_LEN)) begin
                            r_remain <= w_udp_len - 16'(UDP_HDR_LEN);
                            r_state  <= RX_PAYLOAD;
                        end else begin
                            r_state <= RX_DROP;
                        end
                    end else begin
                        r_state <= RX_HDR;
                    end
                end else if (r_state == RX_PAYLOAD) begin
                    if (w_take != 16'd0) begin
                        r_valid   <= 1'b1;
                        r_start   <= !r_emitted;
                        r_emitted <= 1'b1;
                        r_data    <= mac_data_i;
                        r_len     <= w_take[LEN_W-1:0];
                    end
                    r_remain <= r_remain - w_take;
                    if (mac_term_i) begin
                        r_state   <= RX_IDLE;
                        r_emitted <= 1'b0;
                    end else if (r_remain == w_take) begin
                        r_state <= RX_DROP;
                    end
                end else if (r_state == RX_DROP && mac_term_i) begin
                    r_state   <= RX_IDLE;
                    r_emitted <= 1'b0;
                end
            end
        end
    end

    assign app_valid_o  = r_valid;
    assign app_start_o  = r_start;
    assign app_cancel_o = r_cancel;
    assign app_data_o   = r_data;
    assign app_len_o    = r_len;

endmodule

// File: tb/tb_eth_udp_rx.sv
// Directed bench for eth_udp_rx (VLAN, DATA_W=16, src 0.0.0.1 / dst 0.0.0.0 filters).
module tb_eth_udp_rx;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 2;

    logic              clk = 1'b0;
    logic              nreset = 1'b1;
    logic              phy_cancel_i = 1'b0;
    logic              mac_valid_i = 1'b0;
    logic [DATA_W-1:0] mac_data_i = '0;
    logic [0:0]        mac_start_i = '0;
    logic              mac_term_i = 1'b0;
    logic [LEN_W-1:0]  mac_len_i = '0;
    logic              app_valid_o;
    logic              app_start_o;
    logic              app_cancel_o;
    logic [DATA_W-1:0] app_data_o;
    logic [LEN_W-1:0]  app_len_o;

    eth_udp_rx #(
        .IS_10G            (1),
        .VLAN_TAG          (1),
        .DATA_W            (DATA_W),
        .MATCH_IP_SRC_ADDR (1),
        .MATCH_IP_DST_ADDR (1),
        .IP_SRC_ADDR       (32'h0000_0001),
        .IP_DST_ADDR       (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .phy_cancel_i (phy_cancel_i),
        .mac_valid_i  (mac_valid_i),
        .mac_data_i   (mac_data_i),
        .mac_start_i  (mac_start_i),
        .mac_term_i   (mac_term_i),
        .mac_len_i    (mac_len_i),
        .app_valid_o  (app_valid_o),
        .app_start_o  (app_start_o),
        .app_cancel_o (app_cancel_o),
        .app_data_o   (app_data_o),
        .app_len_o    (app_len_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] src;
        logic [7:0]  proto;
        logic [15:0] etype;
        int          udp_len;
        int          npay;
        int          total;
        int          trunc;
        int          gap;
        int          exp_n;
    } vec_t;

    typedef struct {
        logic              valid;
        logic              start;
        logic              cancel;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } obs_t;

    localparam int NV = 13;
    vec_t       vt[NV];
    obs_t       mon_q[$];
    logic [7:0] fb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         x_cnt = 0;
    int         beat_no = 0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if ($isunknown({app_valid_o, app_start_o, app_cancel_o, app_len_o, app_data_o}))
            x_cnt++;
        if (app_valid_o === 1'b1 || app_cancel_o === 1'b1)
            mon_q.push_back('{valid: app_valid_o, start: app_start_o, cancel: app_cancel_o,
                              data: app_data_o, len: app_len_o});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build(input logic [31:0] src, input logic [7:0] proto, input logic [15:0] etype,
                         input int udp_len, input int npay, input int total);
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 6; i++) fb.push_back(8'h20 + 8'(i));
        fb.push_back(8'h81); fb.push_back(8'h00); fb.push_back(8'h00); fb.push_back(8'h05);
        fb.push_back(etype[15:8]); fb.push_back(etype[7:0]);
        fb.push_back(8'h45); fb.push_back(8'h00);
        fb.push_back(8'h00); fb.push_back(8'(20 + udp_len));
        fb.push_back(8'h00); fb.push_back(8'h00); fb.push_back(8'h00); fb.push_back(8'h00);
        fb.push_back(8'h40); fb.push_back(proto); fb.push_back(8'h00); fb.push_back(8'h00);
        for (int i = 3; i >= 0; i--) fb.push_back(src[8*i +: 8]);
        for (int i = 0; i < 4; i++) fb.push_back(8'h00);
        fb.push_back(8'h04); fb.push_back(8'hD2); fb.push_back(8'h16); fb.push_back(8'h2E);
        fb.push_back(8'(udp_len >> 8)); fb.push_back(8'(udp_len));
        fb.push_back(8'h00); fb.push_back(8'h00);
        for (int i = 0; i < npay; i++) fb.push_back(8'(i + 1));
        while (fb.size() < total) fb.push_back(8'hEE);
    endtask

    task automatic idle_x_beat();
        @(posedge clk); #1;
        mac_valid_i  = 1'b0;
        phy_cancel_i = 1'bx;
        mac_start_i  = 'x;
        mac_term_i   = 1'bx;
        mac_len_i    = 'x;
        mac_data_i   = 'x;
    endtask

    // Drive nbytes of fb; cancel_beat/stop_beat of -1 disable those features.
    task automatic send(input int nbytes, input int gap, input int cancel_beat, input int stop_beat);
        int nb;
        logic [7:0] hi;
        nb = (nbytes + 1) / 2;
        for (int k = 0; k < nb; k++) begin
            if (k == stop_beat) break;
            beat_no++;
            if (gap != 0 && (beat_no % gap) == 0) idle_x_beat();
            @(posedge clk); #1;
            hi = (2*k + 1 < nbytes) ? fb[2*k + 1] : 8'hA5;
            mac_valid_i  = 1'b1;
            mac_start_i  = (k == 0) ? 1'b1 : 1'b0;
            mac_term_i   = (k == nb - 1);
            phy_cancel_i = (k == cancel_beat);
            mac_data_i   = {hi, fb[2*k]};
            mac_len_i    = (2*k + 1 < nbytes) ? 2'd2 : 2'd1;
        end
        @(posedge clk); #1;
        mac_valid_i  = 1'b0;
        phy_cancel_i = 1'b0;
        mac_start_i  = '0;
        mac_term_i   = 1'b0;
    endtask

    task automatic compare(input string tag, input int exp_n);
        int nb;
        int n;
        logic [7:0] b0;
        logic [7:0] b1;
        nb = (exp_n + 1) / 2;
        chk($sformatf("%s beats", tag), mon_q.size(), nb);
        n = (mon_q.size() < nb) ? mon_q.size() : nb;
        for (int i = 0; i < n; i++) begin
            b0 = 8'(2*i + 1);
            b1 = 8'(2*i + 2);
            chk($sformatf("%s b%0d valid/cancel", tag, i), {mon_q[i].valid, mon_q[i].cancel}, 2'b10);
            chk($sformatf("%s b%0d start", tag, i), mon_q[i].start, (i == 0));
            if (2*i + 1 < exp_n) begin
                chk($sformatf("%s b%0d len", tag, i), mon_q[i].len, 2);
                chk($sformatf("%s b%0d data", tag, i), mon_q[i].data, {b1, b0});
            end else begin
                chk($sformatf("%s b%0d len", tag, i), mon_q[i].len, 1);
                chk($sformatf("%s b%0d data", tag, i), mon_q[i].data[7:0], b0);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int nbytes;
        mon_q.delete();
        build(v.src, v.proto, v.etype, v.udp_len, v.npay, v.total);
        nbytes = (v.trunc != 0) ? v.trunc : fb.size();
        send(nbytes, v.gap, -1, -1);
        repeat (3) @(posedge clk);
        #1;
        compare(tag, v.exp_n);
    endtask

    initial begin
        //        src           proto  etype     ulen npay tot trunc gap exp_n
        vt[0]  = '{32'h1, 8'd17, 16'h0800, 14,  6,  0,  0,   0,  6};
        vt[1]  = '{32'h1, 8'd17, 16'h0800, 15,  7,  0,  0,  33,  7};
        vt[2]  = '{32'h2, 8'd17, 16'h0800, 14,  6,  0,  0,   0,  0};
        vt[3]  = '{32'h1, 8'd6,  16'h0800, 14,  6,  0,  0,   0,  0};
        vt[4]  = '{32'h1, 8'd17, 16'h86DD, 14,  6,  0,  0,   0,  0};
        vt[5]  = '{32'h1, 8'd17, 16'h0800, 12,  4,  0,  0,   0,  4};
        vt[6]  = '{32'h1, 8'd17, 16'h0800,  9,  1, 60,  0,   0,  1};
        vt[7]  = '{32'h1, 8'd17, 16'h0800,  7,  4,  0,  0,   0,  0};
        vt[8]  = '{32'h1, 8'd17, 16'h0800,  8,  0, 60,  0,   0,  0};
        vt[9]  = '{32'h1, 8'd17, 16'h0800, 14,  6,  0, 30,   0,  0};
        vt[10] = '{32'h1, 8'd17, 16'h0800, 15,  7,  0,  0,   5,  7};
        vt[11] = '{32'h1, 8'd17, 16'h0800,  9,  1, 60,  0,   3,  1};
        vt[12] = '{32'h1, 8'd17, 16'h0800, 20, 12,  0,  0,   0, 12};

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {app_valid_o, app_start_o, app_cancel_o, app_len_o, app_data_o}, 0);
        nreset = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < NV; v++) run_vec(vt[v], $sformatf("vec%0d", v));

        // Cancel on the second payload beat: one emitted beat, then one cancel pulse.
        mon_q.delete();
        build(32'h1, 8'd17, 16'h0800, 14, 6, 0);
        send(fb.size(), 0, 24, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("pcancel entries", mon_q.size(), 2);
        if (mon_q.size() >= 2) begin
            chk("pcancel b0 start/valid/cancel", {mon_q[0].start, mon_q[0].valid, mon_q[0].cancel}, 3'b110);
            chk("pcancel b0 data", mon_q[0].data, 16'h0201);
            chk("pcancel pulse valid/cancel", {mon_q[1].valid, mon_q[1].cancel}, 2'b01);
        end

        // Cancel during the header: nothing at all.
        mon_q.delete();
        send(fb.size(), 0, 5, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("hcancel entries", mon_q.size(), 0);
        run_vec(vt[0], "after hcancel");

        // Reset in the middle of the payload.
        mon_q.delete();
        build(32'h1, 8'd17, 16'h0800, 14, 6, 0);
        send(fb.size(), 0, -1, 25);
        chk("pre-reset valid", app_valid_o, 1);
        nreset = 1'b1;
        #1;
        chk("mid-payload reset outputs",
            {app_valid_o, app_start_o, app_cancel_o, app_len_o, app_data_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        run_vec(vt[0], "after reset");

        chk("no X on outputs", x_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eth_udp_rx.md
Name: eth_udp_rx

Overview:
- Receive-side Ethernet/IPv4/UDP header stripper.
- Sits between the MAC/PCS receive interface and the application.
- Consumes a byte stream starting at the destination MAC and delivers only the UDP payload.
- Drops frames that are not IPv4/UDP or whose IP addresses do not match the configured values, and propagates cancels.

Parameters:
- IS_10G, 1: 10G PCS mode; sets start-lane count (always 1 for supported DATA_W).
- VLAN_TAG, 1: 1 = 802.1Q tag (TPID 0x8100) mandatory at bytes 12-15; 0 = untagged.
- DATA_W, 16: datapath width; only 8 or 16 are legal (both header sizes are then beat-aligned).
- MATCH_IP_SRC_ADDR, 1: enable IPv4 source address filter.
- MATCH_IP_DST_ADDR, 1: enable IPv4 destination address filter.
- IP_SRC_ADDR, 32'h1: required IPv4 source address.
- IP_DST_ADDR, 32'h0: required IPv4 destination address.
- Derived: KEEP_W=DATA_W/8; LEN_W=$clog2(KEEP_W+1); LANE0_CNT_N=(IS_10G && DATA_W==64)?2:1.

Ports:
- clk  in  1  clock
- nreset  in  1  reset; asynchronous, active-high despite the name
- phy_cancel_i  in  1  abort current frame (qualified by mac_valid_i)
- mac_valid_i  in  1  beat valid; all other inputs are don't-care (may be X) when low
- mac_data_i  in  DATA_W  frame bytes; first byte in [7:0]
- mac_start_i  in  LANE0_CNT_N  first beat of frame
- mac_term_i  in  1  last beat of frame
- mac_len_i  in  LEN_W  valid bytes on this beat (0..KEEP_W), low lanes first
- app_valid_o  out  1  payload beat valid
- app_start_o  out  1  first payload beat
- app_cancel_o  out  1  one-cycle pulse; payload already delivered must be discarded
- app_data_o  out  DATA_W  payload bytes, byte 0 in [7:0]
- app_len_o  out  LEN_W  valid payload bytes on this beat

Behaviour:
- Frame layout: FCS is already removed upstream.
  - Ethernet header is 14 bytes, or 18 with VLAN_TAG.
  - IPv4 header is 20 bytes; IHL must be 5.
  - UDP header is 8 bytes.
  - Header total is 42 bytes, or 46 with VLAN_TAG.
- Multi-byte fields are big-endian: the first received byte is the MSB.
- Beats with mac_valid_i=0 are ignored entirely: no state change, app_valid_o=0 that cycle. Invalid beats may appear anywhere within a frame.
- State machine:
  - IDLE: mac_valid_i & mac_start_i -> HDR with byte counter = KEEP_W.
  - HDR: capture fields and count bytes. Move to PAYLOAD when the counter reaches the header size, or to DROP on a check failure.
  - PAYLOAD: stream payload bytes.
  - DROP: wait for term or start.
- Checks (any failure -> DROP, producing no output):
  - TPID == 0x8100 when VLAN_TAG=1.
  - EtherType == 0x0800.
  - Version == 4 and IHL == 5.
  - Protocol == 17.
  - Source address == IP_SRC_ADDR when MATCH_IP_SRC_ADDR=1.
  - Destination address == IP_DST_ADDR when MATCH_IP_DST_ADDR=1.
  - The address checks are evaluated once all relevant bytes are captured.
- Payload streaming:
  - A remaining-length counter loads UDP length - 8. Each beat outputs min(mac_len_i, remaining) bytes.
  - Bytes past the UDP length (Ethernet padding) are suppressed. When remaining reaches 0, go to DROP until term.
  - Beats yielding 0 bytes produce no output.
- UDP length < 8 -> DROP.
- The first emitted payload beat has app_start_o=1.
- Latency: outputs are registered, one cycle after the accepted input beat.
- app_data_o bytes at or above app_len_o are don't-care.
- mac_term_i in IDLE, HDR or DROP -> IDLE. A runt frame (term before header complete) produces no output.
- mac_term_i in PAYLOAD -> emit that beat's bytes (if any), then IDLE.
- phy_cancel_i (valid beat):
  - If any payload beat was already emitted for this frame: app_cancel_o=1 next cycle with app_valid_o=0.
  - Always return to IDLE.
- mac_start_i while not IDLE:
  - The old frame is cancelled, with the same app_cancel_o rule as phy_cancel_i.
  - The new frame is parsed from this beat.
  - Start and cancel on the same beat: cancel wins and the beat is dropped.
- Reset: state IDLE, counters 0, all outputs 0.

Decomposition:
- Package eth_pkg holds:
  - Constants: ETH_HDR_LEN (14), VLAN_TAG_LEN (4), TPID 0x8100, ETYPE_IPV4 0x0800, IP_HDR_LEN (20), IP_PROTO_UDP (17), UDP_HDR_LEN (8).
  - The rx state enum.
- One sub-module, eth_udp_rx_filter: combinational field comparison returning pass/fail per header byte offset.

Test Plan:
- Valid VLAN UDP frame with src 0.0.0.1, dst 0.0.0.0, UDP length 14, payload 01..06, DATA_W=16 -> 3 beats, len 2/2/2. First beat has app_start_o=1 and data 16'h0201.
- Same frame with an odd 7-byte payload -> last beat len 1, byte 0x07. Insert mac_valid_i=0 with X inputs every 33rd cycle -> identical output, no X on outputs.
- Source address 0.0.0.2, or protocol 6, or EtherType 0x86DD -> app_valid_o never asserted. The next frame is accepted normally.
- 60-byte padded frame with UDP length 9 (1-byte payload) -> a single beat, len 1, app_start_o=1. Padding is not output.
- phy_cancel_i on payload beat 2 -> app_cancel_o pulses once with app_valid_o=0. phy_cancel_i during the header -> no output at all.
- Reset asserted mid-payload -> all outputs 0 immediately. The next frame starting after reset release is parsed correctly.
